// File: rtl/ping_sched_pkg.sv
// Shared state encoding and default timing for the ultrasound ping sequencer.
package ping_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_FIRE,
        ST_BLANK,
        ST_SAMPLE,
        ST_HOLDOFF,
        ST_WAIT_TRIG
    } state_t;

    localparam int DEF_CH_NUM     = 4;
    localparam int DEF_CH_W       = 2;
    localparam int DEF_PERIOD_CYC = 500000;
    localparam int DEF_SETTLE_CYC = 2500;
    localparam int DEF_BLANK_CYC  = 150000;
    localparam int DEF_SAMPLE_CYC = 150000;
    localparam int DEF_SAMPLE_DIV = 50;

endpackage

// File: rtl/ping_scheduler_rr_ch_picker.sv
// Combinational round-robin channel search: lowest enabled channel strictly above
// prev_ch (wrapping), or from channel 0 inclusive on the first slot after a start.
module rr_ch_picker
    import ping_sched_pkg::*;
#(
    parameter int CH_NUM = DEF_CH_NUM,
    parameter int CH_W   = DEF_CH_W
) (
    input  logic [CH_NUM-1:0] mask,
    input  logic [CH_W-1:0]   prev_ch,
    input  logic              first_slot,
    output logic [CH_W-1:0]   next_ch,
    output logic              none_en
);

    int                start_pos;
    int                pos;
    logic [CH_NUM-1:0] rot;

    // Rotate the mask so the search origin sits at bit 0, then take the lowest set bit.
    always_comb begin
        start_pos = first_slot ? 0 : int'(prev_ch) + 1;
        rot       = CH_NUM'({mask, mask} >> start_pos);
        pos       = 0;
        next_ch   = prev_ch;
        none_en   = 1'b1;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = start_pos + i;
                if (pos >= CH_NUM) pos = pos - CH_NUM;
                next_ch = CH_W'(pos);
                none_en = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ping_scheduler.sv
// Round-robin ping slot sequencer driving relay mux, excitation and AD capture.
// Optional external trigger gate per slot is enabled with PING_EXT_TRIG_EN.
module ping_scheduler
    import ping_sched_pkg::*;
#(
    parameter int CH_NUM     = DEF_CH_NUM,
    parameter int CH_W       = DEF_CH_W,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int BLANK_CYC  = DEF_BLANK_CYC,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic              clk_50M,
    input  logic              rst,
`ifdef PING_EXT_TRIG_EN
    input  logic              ext_trig,
`endif
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [CH_NUM-1:0] ch_mask,
    input  logic [15:0]       ping_total,
    output logic [CH_W-1:0]   ch_sel,
    output logic              exc_start,
    output logic              ad_start,
    output logic              window_active,
    output logic              ping_done,
    output logic              busy,
    output logic [15:0]       ping_count,
    output logic              err_no_ch
);

    // state      | meaning
    // IDLE       | waiting for cmd_start
    // WAIT_TRIG  | slot armed, waiting for ext_trig (t held at 0)
    // SELECT     | t=0, channel chosen on entry, err_no_ch if mask empty
    // SETTLE     | t=1..SETTLE_CYC, relay mux settling
    // FIRE       | single excitation cycle
    // BLANK      | blind zone after excitation
    // SAMPLE     | AD window, ad_start every SAMPLE_DIV cycles
    // HOLDOFF    | pad to end of period, ping_done on t=PERIOD_CYC-1

    localparam int TW = $clog2(PERIOD_CYC);
    localparam int DW = $clog2(SAMPLE_DIV);

    localparam logic [TW-1:0] T_SETTLE_END = TW'(SETTLE_CYC);
    localparam logic [TW-1:0] T_BLANK_END  = TW'(SETTLE_CYC + 1 + BLANK_CYC);
    localparam logic [TW-1:0] T_SAMPLE_END = TW'(SETTLE_CYC + 1 + BLANK_CYC + SAMPLE_CYC);
    localparam logic [TW-1:0] T_DONE_PRE   = TW'(PERIOD_CYC - 2);
    localparam logic [TW-1:0] T_LAST       = TW'(PERIOD_CYC - 1);
    localparam logic [DW-1:0] AD_RELOAD    = DW'(SAMPLE_DIV - 1);

`ifdef PING_EXT_TRIG_EN
    localparam bit EXT_MODE = 1'b1;
`else
    localparam bit EXT_MODE = 1'b0;
`endif

    state_t          state;
    state_t          slot_next;
    logic [TW-1:0]   t;
    logic [DW-1:0]   ad_cnt;
    logic [15:0]     total_q;
    logic            first_slot;
    logic            stop_now;
    logic            last_ping;
    logic            enter_select;
    logic [CH_W-1:0] pick_ch;
    logic            pick_none;

    assign stop_now  = (state != ST_IDLE) && cmd_stop;
    assign last_ping = (total_q != 16'd0) && (ping_count == total_q);
    assign slot_next = EXT_MODE ? ST_WAIT_TRIG : ST_SELECT;

    rr_ch_picker #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_picker (
        .mask       (ch_mask),
        .prev_ch    (ch_sel),
        .first_slot (first_slot || (state == ST_IDLE)),
        .next_ch    (pick_ch),
        .none_en    (pick_none)
    );

    // Channel selection happens on the edge into SELECT so ch_sel and err_no_ch are valid during it.
    always_comb begin
        enter_select = 1'b0;
        if (!stop_now) begin
            case (state)
                ST_IDLE:      enter_select = cmd_start && !cmd_stop && !EXT_MODE;
                ST_HOLDOFF:   enter_select = (t == T_LAST) && !last_ping && !EXT_MODE;
`ifdef PING_EXT_TRIG_EN
                ST_WAIT_TRIG: enter_select = ext_trig;
`endif
                default:      enter_select = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state         <= ST_IDLE;
            ch_sel        <= '0;
            ping_count    <= '0;
            exc_start     <= 1'b0;
            ad_start      <= 1'b0;
            window_active <= 1'b0;
            ping_done     <= 1'b0;
            busy          <= 1'b0;
            err_no_ch     <= 1'b0;
            t             <= '0;
            ad_cnt        <= '0;
            total_q       <= '0;
            first_slot    <= 1'b0;
        end else begin
            exc_start <= 1'b0;
            ad_start  <= 1'b0;
            ping_done <= 1'b0;
            err_no_ch <= 1'b0;
            if (stop_now) begin
                state         <= ST_IDLE;
                busy          <= 1'b0;
                window_active <= 1'b0;
                t             <= '0;
            end else begin
                t <= t + 1'b1;
                case (state)
                    ST_IDLE: begin
                        t <= '0;
                        if (cmd_start && !cmd_stop) begin
                            ping_count <= '0;
                            total_q    <= ping_total;
                            first_slot <= 1'b1;
                            busy       <= 1'b1;
                            state      <= slot_next;
                        end
                    end
`ifdef PING_EXT_TRIG_EN
                    ST_WAIT_TRIG: begin
                        t <= '0;
                        if (ext_trig) state <= ST_SELECT;
                    end
`endif
                    ST_SELECT: begin
                        if (err_no_ch) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (t == T_SETTLE_END) begin
                            state     <= ST_FIRE;
                            exc_start <= 1'b1;
                        end
                    end
                    ST_FIRE: state <= ST_BLANK;
                    ST_BLANK: begin
                        if (t == T_BLANK_END) begin
                            state         <= ST_SAMPLE;
                            window_active <= 1'b1;
                            ad_start      <= 1'b1;
                            ad_cnt        <= AD_RELOAD;
                        end
                    end
                    ST_SAMPLE: begin
                        if (t == T_SAMPLE_END) begin
                            state         <= ST_HOLDOFF;
                            window_active <= 1'b0;
                        end else if (ad_cnt == '0) begin
                            ad_start <= 1'b1;
                            ad_cnt   <= AD_RELOAD;
                        end else begin
                            ad_cnt <= ad_cnt - 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (t == T_LAST) begin
                            t <= '0;
                            if (last_ping) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= slot_next;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                if ((state == ST_SAMPLE || state == ST_HOLDOFF) && t == T_DONE_PRE) begin
                    ping_done <= 1'b1;
                    if (ping_count != 16'hFFFF) ping_count <= ping_count + 16'd1;
                end

                if (enter_select) begin
                    state      <= ST_SELECT;
                    t          <= '0;
                    first_slot <= 1'b0;
                    err_no_ch  <= pick_none;
                    if (!pick_none) ch_sel <= pick_ch;
                end
            end
        end
    end

endmodule

// File: tb/tb_ping_scheduler.sv
// Self-checking bench for ping_scheduler: directed steps plus randomized runs
// compared every cycle against a slot-offset timeline model.
module tb_ping_scheduler;

    localparam int CH_NUM     = 4;
    localparam int CH_W       = 2;
    localparam int PERIOD_CYC = 100;
    localparam int SETTLE_CYC = 5;
    localparam int BLANK_CYC  = 10;
    localparam int SAMPLE_CYC = 40;
    localparam int SAMPLE_DIV = 8;
    localparam int FIRE_OFS   = SETTLE_CYC + 1;
    localparam int WIN_FIRST  = SETTLE_CYC + 2 + BLANK_CYC;
    localparam int WIN_LAST   = WIN_FIRST + SAMPLE_CYC - 1;
`ifdef PING_EXT_TRIG_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic              clk_50M = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_start = 1'b0;
    logic              cmd_stop = 1'b0;
    logic [CH_NUM-1:0] ch_mask = '0;
    logic [15:0]       ping_total = '0;
`ifdef PING_EXT_TRIG_EN
    logic              ext_trig = 1'b0;
`endif
    logic [CH_W-1:0]   ch_sel;
    logic              exc_start, ad_start, window_active, ping_done, busy, err_no_ch;
    logic [15:0]       ping_count;

    ping_scheduler #(
        .CH_NUM     (CH_NUM),
        .CH_W       (CH_W),
        .PERIOD_CYC (PERIOD_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .BLANK_CYC  (BLANK_CYC),
        .SAMPLE_CYC (SAMPLE_CYC),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clk_50M       (clk_50M),
        .rst           (rst),
`ifdef PING_EXT_TRIG_EN
        .ext_trig      (ext_trig),
`endif
        .cmd_start     (cmd_start),
        .cmd_stop      (cmd_stop),
        .ch_mask       (ch_mask),
        .ping_total    (ping_total),
        .ch_sel        (ch_sel),
        .exc_start     (exc_start),
        .ad_start      (ad_start),
        .window_active (window_active),
        .ping_done     (ping_done),
        .busy          (busy),
        .ping_count    (ping_count),
        .err_no_ch     (err_no_ch)
    );

    always #10 clk_50M = ~clk_50M;

    int tests = 0;
    int failed = 0;

    // Reference model: run/wait flags, offset within the current slot, channel, counts.
    bit m_run, m_wait, m_err, m_first;
    int m_o, m_ch, m_count, m_total;
    int n_exc, n_ad, n_done, n_err;
    int exc_ch_q[$];

    function automatic int pick(input logic [CH_NUM-1:0] mask, input int prev, input bit first);
        int c;
        int r;
        r = -1;
        for (int k = 0; k < CH_NUM; k++) begin
            c = first ? k : (prev + 1 + k) % CH_NUM;
            if (r < 0 && mask[c[CH_W-1:0]]) r = c;
        end
        return r;
    endfunction

    task automatic begin_slot();
        int c;
        m_o = 0;
        c = pick(ch_mask, m_ch, m_first);
        if (c < 0) m_err = 1'b1;
        else begin
            m_ch  = c;
            m_err = 1'b0;
        end
        m_first = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_wait = 0; m_err = 0; m_first = 0;
            m_o = 0; m_ch = 0; m_count = 0; m_total = 0;
        end else if (m_run && cmd_stop) begin
            m_run = 0; m_wait = 0; m_err = 0;
        end else if (!m_run) begin
            if (cmd_start && !cmd_stop) begin
                m_run = 1; m_count = 0; m_total = int'(ping_total); m_first = 1;
                if (EXT) m_wait = 1;
                else begin_slot();
            end
        end else if (m_wait) begin
`ifdef PING_EXT_TRIG_EN
            if (ext_trig) begin
                m_wait = 0;
                begin_slot();
            end
`endif
        end else if (m_err) begin
            m_run = 0; m_err = 0;
        end else if (m_o == PERIOD_CYC - 1) begin
            if (m_total != 0 && m_count == m_total) m_run = 0;
            else if (EXT) m_wait = 1;
            else begin_slot();
        end else begin
            m_o++;
            if (m_o == PERIOD_CYC - 1 && m_count < 65535) m_count++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit act, e_win, e_ad;
        act   = m_run && !m_wait && !m_err;
        e_win = act && m_o >= WIN_FIRST && m_o <= WIN_LAST;
        e_ad  = e_win && ((m_o - WIN_FIRST) % SAMPLE_DIV == 0);
        chk("busy",          32'(busy),          32'(m_run));
        chk("ch_sel",        32'(ch_sel),        32'(m_ch));
        chk("exc_start",     32'(exc_start),     32'(act && m_o == FIRE_OFS));
        chk("ad_start",      32'(ad_start),      32'(e_ad));
        chk("window_active", 32'(window_active), 32'(e_win));
        chk("ping_done",     32'(ping_done),     32'(act && m_o == PERIOD_CYC - 1));
        chk("err_no_ch",     32'(err_no_ch),     32'(m_run && m_err));
        chk("ping_count",    32'(ping_count),    32'(m_count));
        if (exc_start) begin
            n_exc++;
            exc_ch_q.push_back(int'(ch_sel));
        end
        if (ad_start)  n_ad++;
        if (ping_done) n_done++;
        if (err_no_ch) n_err++;
    endtask

    task automatic step();
        @(posedge clk_50M);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic clr_counts();
        n_exc = 0; n_ad = 0; n_done = 0; n_err = 0;
        exc_ch_q.delete();
    endtask

    initial begin
        int exp_seq[4];
        int stop_at;
        int ad_snap;
        exp_seq = '{1, 3, 1, 3};

        // reset and idle
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(3);

        // single ping on all channels
        clr_counts();
        ch_mask = 4'b1111; ping_total = 16'd1;
        pulse_start();
        run(105);
        chk("t1_ad_count", 32'(n_ad), 32'd5);
        chk("t1_exc_count", 32'(n_exc), 32'd1);
        chk("t1_done_count", 32'(n_done), 32'd1);
        chk("t1_ping_count", 32'(ping_count), 32'd1);

        // four pings on a sparse mask
        clr_counts();
        ch_mask = 4'b1010; ping_total = 16'd4;
        pulse_start();
        run(410);
        chk("t2_exc_count", 32'(exc_ch_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t2_ch_seq", 32'(i < exc_ch_q.size() ? exc_ch_q[i] : -1), 32'(exp_seq[i]));
        chk("t2_done_count", 32'(n_done), 32'd4);
        chk("t2_busy_end", 32'(busy), 32'd0);

        // stop during SAMPLE of ping 2
        clr_counts();
        ch_mask = 4'($urandom_range(1, 15)); ping_total = 16'd0;
        pulse_start();
        run(125);
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        ad_snap = n_ad;
        run(30);
        chk("t3_no_more_ad", 32'(n_ad), 32'(ad_snap));
        chk("t3_done_count", 32'(n_done), 32'd1);
        chk("t3_ping_count", 32'(ping_count), 32'd1);

        // empty mask at start
        clr_counts();
        ch_mask = 4'b0000; ping_total = 16'd2;
        pulse_start();
        run(5);
        chk("t4_err_count", 32'(n_err), 32'd1);
        chk("t4_exc_count", 32'(n_exc), 32'd0);

        // start+stop while idle, then start during a run
        clr_counts();
        ch_mask = 4'b1111; ping_total = 16'd2;
        cmd_start = 1'b1; cmd_stop = 1'b1;
        step();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        chk("t5_idle_both", 32'(busy), 32'd0);
        pulse_start();
        run(50);
        pulse_start();
        run(200);
        chk("t5_ping_count", 32'(ping_count), 32'd2);
        chk("t5_done_count", 32'(n_done), 32'd2);

`ifdef PING_EXT_TRIG_EN
        clr_counts();
        ch_mask = 4'b0011; ping_total = 16'd2; ext_trig = 1'b0;
        pulse_start();
        run(30);
        chk("t6_no_exc_wait", 32'(n_exc), 32'd0);
        ext_trig = 1'b1;
        step();
        ext_trig = 1'b0;
        run(5);
        step();
        chk("t6_trig_exc", 32'(exc_start), 32'd1);
        run(100);
        chk("t6_wait_busy", 32'(busy), 32'd1);
        ext_trig = 1'b1;
        step();
        ext_trig = 1'b0;
        run(105);
        chk("t6_ping_count", 32'(ping_count), 32'd2);
        pulse_start();
        run(5);
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        chk("t6_stop_wait", 32'(busy), 32'd0);
`endif

        // randomized runs: mask changes, spurious starts, stops, one mid-slot reset
        for (int it = 0; it < 6; it++) begin
            ch_mask    = 4'($urandom_range(0, 15));
            ping_total = 16'($urandom_range(0, 3));
            stop_at    = (ping_total == 16'd0) ? int'($urandom_range(20, 250)) : -1;
            pulse_start();
            for (int n = 0; n < 340; n++) begin
                if ($urandom_range(0, 49) == 0) ch_mask = 4'($urandom_range(0, 15));
                if (m_run && $urandom_range(0, 79) == 0) cmd_start = 1'b1;
                if (n == stop_at) cmd_stop = 1'b1;
                if (it == 2 && n == 120) rst = 1'b1;
`ifdef PING_EXT_TRIG_EN
                ext_trig = ($urandom_range(0, 9) == 0);
`endif
                step();
                cmd_start = 1'b0; cmd_stop = 1'b0; rst = 1'b0;
                if (!m_run && n > 2) break;
            end
            chk("rand_idle", 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
